// File: rtl/segway_math_pipe.sv
// Segway motor-speed math: soft-start scaling, steering mix, deadzone shaping,
// saturation/slew and over-speed detection in a 3-stage valid-qualified pipeline.
module segway_math_pipe #(
    parameter int DW          = 12,
    parameter int SS_W        = 8,
    parameter int MIN_DUTY    = 'h0A8,
    parameter int LOW_BAND    = 'h2A,
    parameter int GAIN_MULT   = 4,
    parameter int SLEW_STEP   = 0,
    parameter int FAST_THRESH = 1536,
    parameter int FAST_CNT    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_in,
    input  logic [DW-1:0]        PID_cntrl,
    input  logic [DW-1:0]        steer_pot,
    input  logic                 en_steer,
    input  logic                 pwr_up,
    output logic signed [DW-1:0] lft_spd,
    output logic signed [DW-1:0] rght_spd,
    output logic                 vld_out,
    output logic                 too_fast,
    output logic                 ss_done
);
    // Shaped torque keeps two guard bits so the deadzone offset cannot wrap before the clamp.
    localparam int TW  = DW + 2;
    localparam int DW1 = DW + 1;
    localparam int PW  = DW + SS_W + 1;
    localparam int CW  = (FAST_CNT < 1) ? 1 : $clog2(FAST_CNT + 1);

    localparam logic [DW-1:0]         CLIP_LO  = DW'(1 << (DW - 3));
    localparam logic [DW-1:0]         CLIP_HI  = DW'(7 << (DW - 3));
    localparam logic [DW-1:0]         POT_MID  = DW'((1 << (DW - 1)) - 1);
    localparam logic [DW1-1:0]        BAND_W   = DW1'(LOW_BAND);
    localparam logic signed [TW-1:0]  DUTY_W   = TW'(MIN_DUTY);
    localparam logic signed [TW-1:0]  GAIN_W   = TW'(GAIN_MULT);
    localparam logic signed [TW-1:0]  SAT_HI   = TW'((1 << (DW - 1)) - 1);
    localparam logic signed [TW-1:0]  SAT_LO   = TW'(-(1 << (DW - 1)));
    localparam logic signed [DW1-1:0] STEP_W   = DW1'(SLEW_STEP);
    localparam logic signed [31:0]    THRESH_W = 32'(FAST_THRESH);
    localparam logic [CW-1:0]         CNT_MAX  = CW'(FAST_CNT);

    logic [SS_W-1:0]       ss_tmr_q, ss_tmr_d;
    logic [3:1]            vld_pipe_q, vld_pipe_d;
    logic signed [DW-1:0]  s1_pid_q, s1_pid_d, s1_steer_q, s1_steer_d;
    logic                  s1_en_q, s1_en_d, s1_pwr_q, s1_pwr_d;
    logic signed [TW-1:0]  s2_lft_q, s2_lft_d, s2_rght_q, s2_rght_d;
    logic                  s2_pwr_q, s2_pwr_d;
    logic signed [DW-1:0]  lft_spd_q, lft_spd_d, rght_spd_q, rght_spd_d;
    logic [CW-1:0]         spd_cnt_q, spd_cnt_d;

    logic signed [PW-1:0]  prod;
    logic [DW-1:0]         pot_clip;
    logic signed [DW-1:0]  steer_s;
    logic signed [DW1-1:0] pid_x, steer_x, lft_t, rght_t;
    logic signed [DW-1:0]  lft_tgt, rght_tgt;

    function automatic logic signed [TW-1:0] shape(input logic signed [DW1-1:0] t);
        logic signed [TW-1:0] tx;
        logic [DW1-1:0]       mag;
        tx  = {t[DW1-1], t};
        mag = t[DW1-1] ? $unsigned(-t) : $unsigned(t);
        if (mag > BAND_W) shape = t[DW1-1] ? tx - DUTY_W : tx + DUTY_W;
        else              shape = tx * GAIN_W;
    endfunction

    function automatic logic signed [DW-1:0] clamp(input logic signed [TW-1:0] x);
        logic signed [TW-1:0] c;
        c = x;
        if (x > SAT_HI)      c = SAT_HI;
        else if (x < SAT_LO) c = SAT_LO;
        clamp = c[DW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] slew(input logic signed [DW-1:0] cur,
                                                  input logic signed [DW-1:0] tgt);
        logic signed [DW1-1:0] cur_x, tgt_x, diff, nxt;
        cur_x = {cur[DW-1], cur};
        tgt_x = {tgt[DW-1], tgt};
        diff  = tgt_x - cur_x;
        nxt   = tgt_x;
        if (diff > STEP_W)       nxt = cur_x + STEP_W;
        else if (diff < -STEP_W) nxt = cur_x - STEP_W;
        slew = nxt[DW-1:0];
    endfunction

    // Soft-start timer and stage 1: scale PID by the pre-increment timer, form steering term.
    always_comb begin
        ss_tmr_d = ss_tmr_q;
        if (!pwr_up)                 ss_tmr_d = '0;
        else if (vld_in && !ss_done) ss_tmr_d = ss_tmr_q + SS_W'(1);

        prod     = PW'($signed(PID_cntrl)) * PW'($signed({1'b0, ss_tmr_q}));
        pot_clip = steer_pot;
        if (steer_pot < CLIP_LO)      pot_clip = CLIP_LO;
        else if (steer_pot > CLIP_HI) pot_clip = CLIP_HI;
        steer_s  = $signed(pot_clip - POT_MID);

        vld_pipe_d = {vld_pipe_q[2:1], vld_in};
        s1_pid_d   = s1_pid_q;
        s1_steer_d = s1_steer_q;
        s1_en_d    = s1_en_q;
        s1_pwr_d   = s1_pwr_q;
        if (vld_in) begin
            s1_pid_d   = prod[DW+SS_W-1:SS_W];
            s1_steer_d = (steer_s >>> 3) + (steer_s >>> 4);
            s1_en_d    = en_steer;
            s1_pwr_d   = pwr_up;
        end
    end

    // Stage 2: steering mix and deadzone shaping.
    always_comb begin
        pid_x   = {s1_pid_q[DW-1], s1_pid_q};
        steer_x = {s1_steer_q[DW-1], s1_steer_q};
        lft_t   = s1_en_q ? pid_x + steer_x : pid_x;
        rght_t  = s1_en_q ? pid_x - steer_x : pid_x;

        s2_lft_d  = s2_lft_q;
        s2_rght_d = s2_rght_q;
        s2_pwr_d  = s2_pwr_q;
        if (vld_pipe_q[1]) begin
            s2_lft_d  = s1_pwr_q ? shape(lft_t)  : '0;
            s2_rght_d = s1_pwr_q ? shape(rght_t) : '0;
            s2_pwr_d  = s1_pwr_q;
        end
    end

    // Stage 3: clamp, optional slew, and over-speed tracking on the new outputs.
    always_comb begin
        lft_tgt    = clamp(s2_lft_q);
        rght_tgt   = clamp(s2_rght_q);
        lft_spd_d  = lft_spd_q;
        rght_spd_d = rght_spd_q;
        spd_cnt_d  = spd_cnt_q;
        if (vld_pipe_q[2]) begin
            if (!s2_pwr_q) begin
                lft_spd_d  = '0;
                rght_spd_d = '0;
            end else if (SLEW_STEP == 0) begin
                lft_spd_d  = lft_tgt;
                rght_spd_d = rght_tgt;
            end else begin
                lft_spd_d  = slew(lft_spd_q, lft_tgt);
                rght_spd_d = slew(rght_spd_q, rght_tgt);
            end
            if (32'(lft_spd_d) > THRESH_W || 32'(rght_spd_d) > THRESH_W)
                spd_cnt_d = (spd_cnt_q >= CNT_MAX) ? CNT_MAX : spd_cnt_q + CW'(1);
            else
                spd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_tmr_q   <= '0;
            vld_pipe_q <= '0;
            s1_pid_q   <= '0;
            s1_steer_q <= '0;
            s1_en_q    <= 1'b0;
            s1_pwr_q   <= 1'b0;
            s2_lft_q   <= '0;
            s2_rght_q  <= '0;
            s2_pwr_q   <= 1'b0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
            spd_cnt_q  <= '0;
        end else begin
            ss_tmr_q   <= ss_tmr_d;
            vld_pipe_q <= vld_pipe_d;
            s1_pid_q   <= s1_pid_d;
            s1_steer_q <= s1_steer_d;
            s1_en_q    <= s1_en_d;
            s1_pwr_q   <= s1_pwr_d;
            s2_lft_q   <= s2_lft_d;
            s2_rght_q  <= s2_rght_d;
            s2_pwr_q   <= s2_pwr_d;
            lft_spd_q  <= lft_spd_d;
            rght_spd_q <= rght_spd_d;
            spd_cnt_q  <= spd_cnt_d;
        end
    end

    assign lft_spd  = lft_spd_q;
    assign rght_spd = rght_spd_q;
    assign vld_out  = vld_pipe_q[3];
    assign too_fast = (spd_cnt_q >= CNT_MAX);
    assign ss_done  = &ss_tmr_q;

endmodule
